// File: rtl/return_address_stack_pkg.sv
// Shared branch-type encodings, RAS sizing and the action code passed from
// the slot selector to the stack.
package return_address_stack_pkg;

  localparam int BRANCH_TYPE__LEN = 3;
  localparam int RAS_DEPTH        = 16;
  localparam int FETCH_RATE_HW    = 4;

  typedef enum logic [2:0] {
    BRANCH_TYPE_NONE  = 3'd0,
    BRANCH_TYPE_COND  = 3'd1,
    BRANCH_TYPE_JMP   = 3'd2,
    BRANCH_TYPE_IJMP  = 3'd3,
    BRANCH_TYPE_CALL  = 3'd4,
    BRANCH_TYPE_ICALL = 3'd5,
    BRANCH_TYPE_RET   = 3'd6,
    BRANCH_TYPE_COROU = 3'd7
  } branch_type_e;

  typedef enum logic [1:0] {
    RAS_ACT_NONE    = 2'd0,
    RAS_ACT_PUSH    = 2'd1,
    RAS_ACT_POP     = 2'd2,
    RAS_ACT_POPPUSH = 2'd3
  } ras_action_e;

  // A slot redirects fetch if it is any real branch, except an untaken COND.
  function automatic logic slot_redirects(input logic [2:0] t, input logic taken);
    if (t == BRANCH_TYPE_COND) return taken;
    return (t != BRANCH_TYPE_NONE);
  endfunction

endpackage

// File: rtl/return_address_stack_slot_select.sv
// Priority encoder: finds the first fetch-redirecting slot in the group and
// derives the stack action and the return address of that slot.
module ras_slot_select
  import return_address_stack_pkg::*;
#(
  parameter int FETCH_RATE = FETCH_RATE_HW,
  parameter int ADDR_W     = 64,
  parameter int SLOT_W     = (FETCH_RATE > 1) ? $clog2(FETCH_RATE) : 1
) (
  input  logic [BRANCH_TYPE__LEN*FETCH_RATE-1:0] i_branch_type,
  input  logic [ADDR_W*FETCH_RATE-1:0]           i_pc,
  input  logic [FETCH_RATE-1:0]                  i_is16,
  input  logic [FETCH_RATE-1:0]                  i_pred_taken,
  output logic [SLOT_W-1:0]                      o_slot,
  output ras_action_e                            o_action,
  output logic [ADDR_W-1:0]                      o_ret_addr
);

  logic              w_found;
  branch_type_e      w_type;
  logic [ADDR_W-1:0] w_pc;
  logic              w_c16;

  always_comb begin
    w_found = 1'b0;
    o_slot  = '0;
    w_type  = BRANCH_TYPE_NONE;
    w_pc    = '0;
    w_c16   = 1'b0;
    for (int i = 0; i < FETCH_RATE; i++) begin
      if (!w_found && slot_redirects(i_branch_type[i*BRANCH_TYPE__LEN +: BRANCH_TYPE__LEN],
                                     i_pred_taken[i])) begin
        w_found = 1'b1;
        o_slot  = SLOT_W'(i);
        w_type  = branch_type_e'(i_branch_type[i*BRANCH_TYPE__LEN +: BRANCH_TYPE__LEN]);
        w_pc    = i_pc[i*ADDR_W +: ADDR_W];
        w_c16   = i_is16[i];
      end
    end
  end

  always_comb begin
    case (w_type)
      BRANCH_TYPE_CALL, BRANCH_TYPE_ICALL: o_action = RAS_ACT_PUSH;
      BRANCH_TYPE_RET:                     o_action = RAS_ACT_POP;
      BRANCH_TYPE_COROU:                   o_action = RAS_ACT_POPPUSH;
      default:                             o_action = RAS_ACT_NONE;
    endcase
  end

  assign o_ret_addr = w_pc + (w_c16 ? ADDR_W'(2) : ADDR_W'(4));

endmodule

// File: rtl/return_address_stack.sv
// IF2 return address stack: circular stack with saturating count, checkpoint
// restore on redirect, and a registered prediction at the IF2-IF3 boundary.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int FETCH_RATE = FETCH_RATE_HW,
  parameter int DEPTH      = RAS_DEPTH,
  parameter int PTR_W      = 4,
  parameter int ADDR_W     = 64,
  localparam int SLOT_W    = (FETCH_RATE > 1) ? $clog2(FETCH_RATE) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   Stall,
  input  logic                                   Bubble,
  input  logic [BRANCH_TYPE__LEN*FETCH_RATE-1:0] BranchType_Bus,
  input  logic [ADDR_W*FETCH_RATE-1:0]           PC_Bus,
  input  logic [FETCH_RATE-1:0]                  Is16Bit,
  input  logic [FETCH_RATE-1:0]                  PredTaken,
  input  logic                                   Redirect,
  input  logic [PTR_W:0]                         RestorePtr,
  output logic [PTR_W:0]                         RasCkptPtr,
  output logic [ADDR_W-1:0]                      RasTarget,
  output logic                                   RasValid,
  output logic [SLOT_W-1:0]                      RasSlot
);

  logic [ADDR_W-1:0] r_stack [DEPTH];
  logic [PTR_W-1:0]  r_tos;
  logic [PTR_W:0]    r_count;

  logic [SLOT_W-1:0] w_slot;
  ras_action_e       w_action;
  logic [ADDR_W-1:0] w_ret_addr;
  logic              w_nonempty, w_full, w_is_ret, w_upd, w_we;
  logic [PTR_W-1:0]  w_tos_inc, w_tos_dec, w_tos_nxt, w_waddr;
  logic [PTR_W:0]    w_cnt_nxt;

  ras_slot_select #(.FETCH_RATE(FETCH_RATE), .ADDR_W(ADDR_W), .SLOT_W(SLOT_W)) u_sel (
    .i_branch_type (BranchType_Bus),
    .i_pc          (PC_Bus),
    .i_is16        (Is16Bit),
    .i_pred_taken  (PredTaken),
    .o_slot        (w_slot),
    .o_action      (w_action),
    .o_ret_addr    (w_ret_addr)
  );

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign w_tos_inc  = r_tos + 1'b1;
  assign w_tos_dec  = r_tos - 1'b1;
  assign w_is_ret   = (w_action == RAS_ACT_POP) || (w_action == RAS_ACT_POPPUSH);
  assign w_upd      = ~Redirect & ~Stall & ~Bubble;

  always_comb begin
    w_tos_nxt = r_tos;
    w_cnt_nxt = r_count;
    w_we      = 1'b0;
    w_waddr   = r_tos;
    case (w_action)
      RAS_ACT_PUSH: begin
        w_tos_nxt = w_tos_inc;
        w_cnt_nxt = w_full ? r_count : r_count + 1'b1;
        w_we      = 1'b1;
        w_waddr   = w_tos_inc;
      end
      RAS_ACT_POP: begin
        if (w_nonempty) begin
          w_tos_nxt = w_tos_dec;
          w_cnt_nxt = r_count - 1'b1;
        end
      end
      RAS_ACT_POPPUSH: begin
        w_we = 1'b1;
        // An empty stack has nothing to replace, so the COROU degenerates to a push.
        if (!w_nonempty) begin
          w_tos_nxt = w_tos_inc;
          w_cnt_nxt = (PTR_W+1)'(1);
          w_waddr   = w_tos_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_upd && w_we) r_stack[w_waddr] <= w_ret_addr;
  end

  // IF2 -> IF3 boundary: pointer state and registered prediction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tos      <= '0;
      r_count    <= '0;
      RasValid   <= 1'b0;
      RasTarget  <= '0;
      RasSlot    <= '0;
      RasCkptPtr <= '0;
    end else if (Redirect) begin
      r_tos      <= RestorePtr[PTR_W-1:0];
      r_count    <= RestorePtr[PTR_W] ? (PTR_W+1)'(DEPTH) : '0;
      RasValid   <= 1'b0;
      RasTarget  <= '0;
      RasSlot    <= '0;
      RasCkptPtr <= '0;
    end else if (Bubble) begin
      RasValid   <= 1'b0;
      RasTarget  <= '0;
      RasSlot    <= '0;
      RasCkptPtr <= '0;
    end else if (!Stall) begin
      r_tos      <= w_tos_nxt;
      r_count    <= w_cnt_nxt;
      RasValid   <= w_is_ret && w_nonempty;
      RasTarget  <= r_stack[r_tos];
      RasSlot    <= w_is_ret ? w_slot : '0;
      RasCkptPtr <= {w_nonempty, r_tos};
    end
  end

endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack with a queue-based scoreboard.
module tb_return_address_stack;

  localparam logic [2:0] T_COND  = 3'd1;
  localparam logic [2:0] T_JMP   = 3'd2;
  localparam logic [2:0] T_CALL  = 3'd4;
  localparam logic [2:0] T_ICALL = 3'd5;
  localparam logic [2:0] T_RET   = 3'd6;
  localparam logic [2:0] T_COROU = 3'd7;

  logic         clk;
  logic         rst, Stall, Bubble, Redirect;
  logic [11:0]  BranchType_Bus;
  logic [255:0] PC_Bus;
  logic [3:0]   Is16Bit, PredTaken;
  logic [4:0]   RestorePtr;
  logic [4:0]   RasCkptPtr;
  logic [63:0]  RasTarget;
  logic         RasValid;
  logic [1:0]   RasSlot;

  return_address_stack #(.FETCH_RATE(4), .DEPTH(16), .PTR_W(4), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Bubble(Bubble),
    .BranchType_Bus(BranchType_Bus), .PC_Bus(PC_Bus), .Is16Bit(Is16Bit),
    .PredTaken(PredTaken), .Redirect(Redirect), .RestorePtr(RestorePtr),
    .RasCkptPtr(RasCkptPtr), .RasTarget(RasTarget), .RasValid(RasValid),
    .RasSlot(RasSlot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    bit         vld;
    logic [63:0] tgt;
    logic [1:0] slot;
    logic [4:0] ckpt;
    bit         full;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (RasValid !== e.vld) begin
        bad++;
        $display("FAIL %s valid: got %0b want %0b", e.nm, RasValid, e.vld);
      end
      total++;
      if (RasCkptPtr !== e.ckpt) begin
        bad++;
        $display("FAIL %s ckpt: got %h want %h", e.nm, RasCkptPtr, e.ckpt);
      end
      if (e.full || e.vld) begin
        total++;
        if (RasTarget !== e.tgt) begin
          bad++;
          $display("FAIL %s target: got %h want %h", e.nm, RasTarget, e.tgt);
        end
        total++;
        if (RasSlot !== e.slot) begin
          bad++;
          $display("FAIL %s slot: got %0d want %0d", e.nm, RasSlot, e.slot);
        end
      end
    end
  end

  task automatic clr();
    rst = 1'b0; Stall = 1'b0; Bubble = 1'b0; Redirect = 1'b0; RestorePtr = '0;
    BranchType_Bus = '0; PC_Bus = '0; Is16Bit = '0; PredTaken = '0;
  endtask

  task automatic setslot(input int s, input logic [2:0] t, input logic [63:0] pc,
                         input bit c16, input bit pt);
    BranchType_Bus[s*3 +: 3] = t;
    PC_Bus[s*64 +: 64]       = pc;
    Is16Bit[s]               = c16;
    PredTaken[s]             = pt;
  endtask

  task automatic cyc(input string nm, input bit vld, input logic [63:0] tgt,
                     input logic [1:0] slot, input logic [4:0] ckpt, input bit full);
    exp_t e;
    @(posedge clk);
    #1;
    e.nm = nm; e.vld = vld; e.tgt = tgt; e.slot = slot; e.ckpt = ckpt; e.full = full;
    q.push_back(e);
    @(negedge clk);
  endtask

  logic [4:0] cap;
  logic [4:0] ck;

  initial begin
    clr();
    rst = 1'b1;
    cyc("reset0", 0, 64'h0, 2'd0, 5'h00, 1);
    cyc("reset1", 0, 64'h0, 2'd0, 5'h00, 1);

    // 1: CALL then RET from slot 2
    clr(); setslot(0, T_CALL, 64'h1000, 0, 0);
    cyc("t1call", 0, 64'h0, 2'd0, 5'h00, 0);
    clr(); setslot(2, T_RET, 64'h1100, 0, 0);
    cyc("t1ret", 1, 64'h1004, 2'd2, 5'h11, 1);
    clr(); setslot(0, T_RET, 64'h1200, 0, 0);
    cyc("t1empty", 0, 64'h0, 2'd0, 5'h00, 0);

    // 2: taken COND in slot 0 masks the ICALL in slot 1
    clr(); setslot(0, T_COND, 64'h2000, 0, 1); setslot(1, T_ICALL, 64'h2002, 1, 0);
    cyc("t2taken", 0, 64'h0, 2'd0, 5'h00, 0);
    clr(); setslot(0, T_COND, 64'h2000, 0, 0); setslot(1, T_ICALL, 64'h2002, 1, 0);
    cyc("t2nottaken", 0, 64'h0, 2'd0, 5'h00, 0);
    clr(); setslot(0, T_RET, 64'h2100, 0, 0); setslot(1, T_CALL, 64'h2104, 0, 0);
    cyc("t2ret", 1, 64'h2004, 2'd0, 5'h11, 1);

    // 3: overflow by one, then drain past empty
    for (int k = 1; k <= 17; k++) begin
      clr(); setslot(0, T_CALL, 64'(k * 256), 0, 0);
      ck = (k == 1) ? 5'h00 : {1'b1, 4'((k - 1) % 16)};
      cyc("t3call", 0, 64'h0, 2'd0, ck, 0);
    end
    for (int j = 1; j <= 16; j++) begin
      clr(); setslot(0, T_JMP, 64'h0, 0, 0); setslot(1, T_RET, 64'h8000, 0, 0);
      BranchType_Bus[2:0] = 3'd0;
      cyc("t3ret", 1, 64'(256 * (18 - j) + 4), 2'd1, {1'b1, 4'((18 - j) % 16)}, 1);
    end
    clr(); setslot(1, T_RET, 64'h8000, 0, 0);
    cyc("t3under", 0, 64'h0, 2'd0, 5'h01, 0);

    // 4: COROU swaps the top entry
    clr(); setslot(0, T_CALL, 64'h4000, 0, 0);
    cyc("t4pushA", 0, 64'h0, 2'd0, 5'h01, 0);
    clr(); setslot(0, T_CALL, 64'h4100, 1, 0);
    cyc("t4pushB", 0, 64'h0, 2'd0, 5'h12, 0);
    clr(); setslot(0, T_COROU, 64'h3000, 0, 0);
    cyc("t4corou", 1, 64'h4102, 2'd0, 5'h13, 1);
    clr(); setslot(0, T_RET, 64'h3100, 0, 0);
    cyc("t4ret1", 1, 64'h3004, 2'd0, 5'h13, 1);
    clr(); setslot(0, T_RET, 64'h3200, 0, 0);
    cyc("t4ret2", 1, 64'h4004, 2'd0, 5'h12, 1);
    clr(); setslot(2, T_COROU, 64'h5000, 1, 0);
    cyc("t4corouempty", 0, 64'h0, 2'd0, 5'h01, 0);
    clr(); setslot(3, T_RET, 64'h5100, 0, 0);
    cyc("t4ret3", 1, 64'h5002, 2'd3, 5'h12, 1);

    // 5: checkpoint restore on redirect
    clr(); setslot(0, T_CALL, 64'h6000, 0, 0);
    cyc("t5pushA", 0, 64'h0, 2'd0, 5'h01, 0);
    clr(); setslot(0, T_CALL, 64'h6100, 0, 0);
    cyc("t5pushB", 0, 64'h0, 2'd0, 5'h12, 0);
    cap = RasCkptPtr;
    clr(); setslot(0, T_CALL, 64'h6200, 0, 0);
    cyc("t5pushC", 0, 64'h0, 2'd0, 5'h13, 0);
    clr(); setslot(0, T_CALL, 64'h6300, 0, 0); Redirect = 1'b1; RestorePtr = cap;
    cyc("t5redirect", 0, 64'h0, 2'd0, 5'h00, 1);
    clr(); setslot(0, T_RET, 64'h6400, 0, 0);
    cyc("t5ret", 1, 64'h6004, 2'd0, 5'h12, 1);

    // 6: stall hold, bubble clear, redirect over stall, reset during pop
    clr(); setslot(0, T_CALL, 64'h9000, 0, 0); Stall = 1'b1;
    for (int s = 0; s < 3; s++) cyc("t6stall", 1, 64'h6004, 2'd0, 5'h12, 1);
    clr(); setslot(0, T_RET, 64'h9100, 0, 0);
    cyc("t6ret", 1, 64'h1104, 2'd0, 5'h11, 1);
    clr(); setslot(0, T_RET, 64'h9200, 0, 0); Bubble = 1'b1;
    cyc("t6bubble", 0, 64'h0, 2'd0, 5'h00, 1);
    clr(); setslot(0, T_RET, 64'h9300, 0, 0);
    cyc("t6ret2", 1, 64'h1004, 2'd0, 5'h10, 1);
    clr(); setslot(0, T_RET, 64'h9400, 0, 0); Bubble = 1'b1; Stall = 1'b1;
    cyc("t6bubstall", 0, 64'h0, 2'd0, 5'h00, 1);
    clr(); setslot(0, T_RET, 64'h9500, 0, 0); rst = 1'b1;
    cyc("t6rst", 0, 64'h0, 2'd0, 5'h00, 1);
    clr(); setslot(0, T_RET, 64'h9600, 0, 0);
    cyc("t6postrst", 0, 64'h0, 2'd0, 5'h00, 0);
    clr(); setslot(0, T_CALL, 64'h9700, 0, 0); Stall = 1'b1; Redirect = 1'b1;
    RestorePtr = 5'h05;
    cyc("t6redirstall", 0, 64'h0, 2'd0, 5'h00, 1);
    clr(); setslot(2, T_RET, 64'h9800, 0, 0);
    cyc("t6restored", 0, 64'h0, 2'd0, 5'h05, 0);
    clr(); setslot(0, T_CALL, 64'h7000, 1, 0);
    cyc("t6call", 0, 64'h0, 2'd0, 5'h05, 0);
    clr(); setslot(3, T_RET, 64'h7100, 0, 0);
    cyc("t6ret3", 1, 64'h7002, 2'd3, 5'h16, 1);

    clr();
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
